// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle saturating ALU with start/done handshake and bit-serial shifts
module alu_mc #(
  parameter int WIDTH   = 16,
  parameter int LANE    = 4,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             error
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LANE_MAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LANE_MIN = {1'b1, {(LANE-1){1'b0}}};

  state_t             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic [2:0]         flags_q;
  logic               error_q;

  logic [WIDTH:0]     addsub_ext;
  logic               addsub_ovf;
  logic [WIDTH-1:0]   addsub_sat;
  logic [WIDTH-1:0]   red_sum;
  logic [WIDTH-1:0]   padd_res;
  logic [LANE:0]      lane_sum;
  logic [WIDTH-1:0]   shift_step;
  logic               is_shift;
  logic               is_arith;
  logic               last_step;
  logic [WIDTH-1:0]   fin_res_d;
  logic [2:0]         fin_flags_d;
  logic               fin_err_d;

  always_comb begin
    is_shift = (op_q == OP_SLL) || (op_q == OP_SRA) || (op_q == OP_ROR);
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    last_step = !is_shift || (cnt_q <= SHAMT_W'(1));

    // One extra sign bit exposes signed overflow as a mismatch of the top two bits
    if (op_q == OP_SUB) addsub_ext = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    else                addsub_ext = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    addsub_ovf = addsub_ext[WIDTH] ^ addsub_ext[WIDTH-1];
    if (addsub_ovf) addsub_sat = addsub_ext[WIDTH] ? SAT_MIN : SAT_MAX;
    else            addsub_sat = addsub_ext[WIDTH-1:0];

    red_sum = '0;
    for (int i = 0; i < WIDTH/8; i++) begin
      red_sum = red_sum + WIDTH'($signed(a_q[8*i +: 8])) + WIDTH'($signed(b_q[8*i +: 8]));
    end

    padd_res = '0;
    lane_sum = '0;
    for (int i = 0; i < WIDTH/LANE; i++) begin
      lane_sum = {a_q[i*LANE+LANE-1], a_q[i*LANE +: LANE]} +
                 {b_q[i*LANE+LANE-1], b_q[i*LANE +: LANE]};
      if (lane_sum[LANE] ^ lane_sum[LANE-1])
        padd_res[i*LANE +: LANE] = lane_sum[LANE] ? LANE_MIN : LANE_MAX;
      else
        padd_res[i*LANE +: LANE] = lane_sum[LANE-1:0];
    end

    case (op_q)
      OP_SLL:  shift_step = {a_q[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_step = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: shift_step = {a_q[0], a_q[WIDTH-1:1]};
    endcase

    case (op_q)
      OP_ADD, OP_SUB:         fin_res_d = addsub_sat;
      OP_XOR:                 fin_res_d = a_q ^ b_q;
      OP_RED:                 fin_res_d = red_sum;
      OP_SLL, OP_SRA, OP_ROR: fin_res_d = (cnt_q == '0) ? a_q : shift_step;
      default:                fin_res_d = padd_res;
    endcase

    fin_err_d   = is_arith & addsub_ovf;
    fin_flags_d = {fin_res_d == '0,
                   is_arith ? addsub_ovf : flags_q[1],
                   is_arith ? addsub_sat[WIDTH-1] : flags_q[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        S_EXEC: begin
          if (last_step) begin
            result_q <= fin_res_d;
            flags_q  <= fin_flags_d;
            error_q  <= fin_err_d;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            // Shifts walk a_q one bit position per cycle
            a_q   <= shift_step;
            cnt_q <= cnt_q - SHAMT_W'(1);
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= opcode;
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= b[SHAMT_W-1:0];
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;
  assign error  = error_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc against a behavioural model
module tb_alu_mc;
  localparam int W = 16;
  localparam int L = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [2:0]   flags;
  logic         error;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_result;
  logic [2:0]   m_flags;

  alu_mc #(.WIDTH(W), .LANE(L), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic e);
    longint sx, sy, s, acc, la, lmax, lmin, maxv, minv;
    int sh;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y[3:0]);
    maxv = (64'sd1 <<< (W-1)) - 1;
    minv = -(64'sd1 <<< (W-1));
    e = 1'b0;
    r = '0;
    case (op)
      3'd0, 3'd1: begin
        s = (op == 3'd0) ? sx + sy : sx - sy;
        if (s > maxv)      begin r = W'(maxv); e = 1'b1; end
        else if (s < minv) begin r = W'(minv); e = 1'b1; end
        else               r = W'(s);
      end
      3'd2: r = x ^ y;
      3'd3: begin
        acc = 0;
        for (int i = 0; i < W/8; i++) begin
          la = $signed(x[8*i +: 8]);
          acc += la;
          la = $signed(y[8*i +: 8]);
          acc += la;
        end
        r = W'(acc);
      end
      3'd4: r = x << sh;
      3'd5: r = W'(sx >>> sh);
      3'd6: r = (sh == 0) ? x : ((x >> sh) | (x << (W - sh)));
      default: begin
        lmax = (64'sd1 <<< (L-1)) - 1;
        lmin = -(64'sd1 <<< (L-1));
        for (int i = 0; i < W/L; i++) begin
          la = $signed(x[L*i +: L]);
          s  = $signed(y[L*i +: L]);
          s  = s + la;
          if (s > lmax) s = lmax;
          if (s < lmin) s = lmin;
          r[L*i +: L] = L'(s);
        end
      end
    endcase
    m_flags[2] = (r == '0);
    if (op == 3'd0 || op == 3'd1) begin
      m_flags[1] = e;
      m_flags[0] = r[W-1];
    end
  endtask

  // Called mid-cycle; returns mid-cycle in the done cycle so a following call is back-to-back
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         e;
    logic [W-1:0] prev;
    logic [2:0]   prev_flags;
    int           n;
    int           cyc;
    prev = m_result;
    prev_flags = m_flags;
    model(op, x, y, r, e);
    n = (op >= 3'd4 && op <= 3'd6) ? ((y[3:0] == 4'd0) ? 1 : int'(y[3:0])) : 1;
    start = 1'b1; opcode = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; opcode = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      check({tag, "_busy"}, 64'(busy), 64'(1));
      check({tag, "_hold"}, 64'({result, flags}), 64'({prev, prev_flags}));
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"},   64'(cyc), 64'(n));
    check({tag, "_res"},   64'(result), 64'(r));
    check({tag, "_err"},   64'(error), 64'(e));
    check({tag, "_flags"}, 64'(flags), 64'(m_flags));
    check({tag, "_nbusy"}, 64'(busy), 64'(0));
    m_result = r;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    check({tag, "_done1"}, 64'(done), 64'(0));
    check({tag, "_idle"},  64'(busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; a = '0; b = '0;
    m_result = '0; m_flags = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   64'(busy),   64'(0));
    check("rst_done",   64'(done),   64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_flags",  64'(flags),  64'(0));
    check("rst_error",  64'(error),  64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001);
    check("add_ovf_const", 64'({result, error, flags}), 64'({16'h7FFF, 1'b1, 3'b010}));
    idle_cycle("add_ovf");

    run_op("sub_zero", 3'd1, 16'h0005, 16'h0005);
    check("sub_const", 64'({result, flags}), 64'({16'h0000, 3'b100}));
    run_op("xor_b2b", 3'd2, 16'h00FF, 16'h00FF);
    check("xor_const", 64'({result, flags}), 64'({16'h0000, 3'b100}));
    idle_cycle("xor_b2b");

    run_op("paddsb", 3'd7, 16'h7F19, 16'h1127);
    check("paddsb_const", 64'({result, error}), 64'({16'h7030, 1'b0}));
    run_op("sra4", 3'd5, 16'h8000, 16'h0004);
    check("sra4_const", 64'(result), 64'(16'hF800));
    run_op("ror1", 3'd6, 16'h0001, 16'h0001);
    check("ror1_const", 64'(result), 64'(16'h8000));
    run_op("sll0", 3'd4, 16'h1234, 16'h0000);
    check("sll0_const", 64'(result), 64'(16'h1234));
    run_op("red_pos", 3'd3, 16'h7F7F, 16'h7F7F);
    check("red_pos_const", 64'({result, error}), 64'({16'h01FC, 1'b0}));
    run_op("red_neg", 3'd3, 16'h8080, 16'h8080);
    check("red_neg_const", 64'({result, error}), 64'({16'hFE00, 1'b0}));
    run_op("sub_negovf", 3'd1, 16'h8000, 16'h0001);
    run_op("xor_keepvn", 3'd2, 16'h1234, 16'h4321);
    idle_cycle("dir_end");

    for (int k = 0; k < 60; k++) begin
      run_op("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      if ($urandom_range(0, 1) == 0) idle_cycle("rand");
    end
    idle_cycle("rand_end");

    start = 1'b1; opcode = 3'd5; a = 16'h8000; b = 16'h000F;
    @(posedge clk); #1;
    opcode = 3'd0; a = 16'h0001; b = 16'h0001;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("abort_busy", 64'(busy), 64'(1));
      check("abort_done", 64'(done), 64'(0));
      check("abort_hold", 64'(result), 64'(m_result));
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_rst", 64'({busy, done, result, flags, error}), 64'(0));
    m_result = '0;
    m_flags  = '0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_nodone", 64'(done), 64'(0));
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({busy, done}), 64'(0));
    run_op("post_rst_add", 3'd0, 16'h1234, 16'h0001);
    check("post_rst_const", 64'({result, error, flags}), 64'({16'h1235, 1'b0, 3'b000}));
    idle_cycle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the next-generation WISC datapath. Supports the same eight ops: ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB.
- Uses a start/done handshake, registered result and flags, saturating arithmetic, and iterative (one bit per cycle) shifts/rotates.
- Sits between the register-file read stage and writeback. The control unit issues one op at a time and stalls on busy.

Parameters:
WIDTH, 16, datapath width; must be a multiple of 8 and of LANE
LANE, 4, PADDSB sub-word lane width in bits; WIDTH % LANE == 0
SHAMT_W, 4, shift-amount field width; equals clog2(WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when ready to accept (IDLE or DONE)
opcode  in  3  000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB
a  in  WIDTH  operand 1
b  in  WIDTH  operand 2; shift/rotate amount is b[SHAMT_W-1:0]
busy  out  1  high while in EXEC
done  out  1  one-cycle pulse; result/flags/error valid from this cycle
result  out  WIDTH  registered result; held until next completion
flags  out  3  {Z,V,N}, registered
error  out  1  overflow/saturation of the last completed op

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, result=0, flags=0, error=0, internal shift counter=0. Reset mid-operation aborts the op and produces no done.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: start=1 at an edge latches opcode, a, b and the shift count; goes to EXEC.
  - EXEC: busy=1; start is ignored. Non-shift ops stay 1 cycle, then go to DONE.
  - Shift/rotate ops stay max(1, shamt) cycles, one bit position per cycle, then go to DONE. Shift by 0 takes 1 cycle with result=a.
  - DONE: done=1 for exactly one cycle. If start=1 here, the new op is latched and the FSM goes to EXEC (back-to-back). Otherwise it returns to IDLE.
- Latency: start accepted at edge 0. done is high after edge N, where N=1 for non-shift ops and N=max(1, shamt) for SLL/SRA/ROR.
- ADD/SUB: signed two's complement, saturating.
  - Positive overflow gives 0111..1; negative overflow gives 1000..0; error=1.
  - Otherwise error=0.
- XOR: bitwise; error=0.
- RED: signed sum of all WIDTH/8 bytes of a plus all WIDTH/8 bytes of b, sign-extended to WIDTH. Never overflows; error=0.
- SLL: zero fill. SRA: MSB fill. ROR: LSB rotates into MSB. error=0 for all three.
- PADDSB: each LANE-bit lane is an independent signed saturating add, clamped to +2^(LANE-1)-1 or -2^(LANE-1). error=0.
- Flags, updated only at completion:
  - Z is updated for every op (result==0).
  - V and N are updated only for ADD/SUB. V=saturation occurred; N=saturated result MSB.
  - All other ops leave V and N unchanged.
- result, flags and error change only on the DONE transition. They are stable between completions, including while busy.

Test Plan:
- ADD a=0x7FFF b=0x0001 (WIDTH=16) -> done after edge 1; result=0x7FFF; error=1; flags Z=0, V=1, N=0.
- SUB a=0x0005 b=0x0005, then XOR a=0x00FF b=0x00FF.
  - After SUB: result=0x0000, Z=1, V=0, N=0.
  - After XOR: result=0x0000, Z=1; V and N keep their SUB values.
  - The XOR start is issued in the SUB DONE cycle and is accepted back-to-back.
- PADDSB a=0x7F19 b=0x1127 (LANE=4) -> result=0x7030 (lane 3 saturates to 7; others 0, 3, 0); error=0.
- SRA a=0x8000 b=0x0004 -> busy high 4 cycles; done after edge 4; result=0xF800.
  - ROR a=0x0001 b=0x0001 -> result=0x8000.
  - SLL a=0x1234 b=0x0000 -> 1 cycle; result=0x1234.
- RED a=0x7F7F b=0x7F7F -> 0x01FC; RED a=0x8080 b=0x8080 -> 0xFE00; both error=0.
- SRA a=0x8000 b=0x000F, then assert start while busy, then drop rst_n after edge 3.
  - start while busy is ignored; busy, done, result and flags are all 0 immediately.
  - After rst_n release, a new ADD completes normally.
